// File: rtl/board_io_pkg.sv
// Shared types for the board I/O controller: reset-sequencer states and PWM width.
package board_io_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } seq_state_e;

  localparam int PWM_W = 4;

endpackage

// File: rtl/board_io_ctrl_debounce_ch.sv
// One debounced input channel: 2-FF synchroniser, disagreement counter and stable register.
module debounce_ch #(
  parameter int DEB_CYC = 1000
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw_i;
      sync2_reg <= sync1_reg;
      // Any cycle of agreement restarts the stability window.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEB_CYC - 1)) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign stable_o = stable_reg;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced switches/buttons, PLL-lock reset sequencer, LED register.
// Define BOARD_IO_PWM_EN to add the pwm_duty_i brightness gate on the LED outputs.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int SW_NUM  = 16,
  parameter int BTN_NUM = 5,
  parameter int LED_NUM = 16,
  parameter int DEB_CYC = 1000,
  parameter int RST_CYC = 16
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               pll_locked_i,
  input  logic [SW_NUM-1:0]  sw_i,
  input  logic [BTN_NUM-1:0] btn_i,
  input  logic               led_we_i,
  input  logic [LED_NUM-1:0] led_wdata_i,
`ifdef BOARD_IO_PWM_EN
  input  logic [PWM_W-1:0]   pwm_duty_i,
`endif
  output logic               srst_o,
  output logic [SW_NUM-1:0]  sw_o,
  output logic [BTN_NUM-1:0] btn_o,
  output logic [BTN_NUM-1:0] btn_pulse_o,
  output logic               irq_o,
  output logic [LED_NUM-1:0] led_o
);

  localparam int RCNT_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  genvar gi;
  generate
    for (gi = 0; gi < SW_NUM; gi++) begin : g_sw
      debounce_ch #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .raw_i(sw_i[gi]), .stable_o(sw_o[gi])
      );
    end
    for (gi = 0; gi < BTN_NUM; gi++) begin : g_btn
      debounce_ch #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .raw_i(btn_i[gi]), .stable_o(btn_o[gi])
      );
    end
  endgenerate

  logic [BTN_NUM-1:0] btn_prev_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) btn_prev_reg <= '0;
    else           btn_prev_reg <= btn_o;
  end

  assign btn_pulse_o = btn_o & ~btn_prev_reg;
  assign irq_o       = |btn_pulse_o;

  logic              lock_s1_reg;
  logic              lock_s2_reg;
  seq_state_e        state_reg, state_next;
  logic [RCNT_W-1:0] rcnt_reg, rcnt_next;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lock_s1_reg <= 1'b0;
      lock_s2_reg <= 1'b0;
      state_reg   <= HOLD;
      rcnt_reg    <= '0;
    end else begin
      lock_s1_reg <= pll_locked_i;
      lock_s2_reg <= lock_s1_reg;
      state_reg   <= state_next;
      rcnt_reg    <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rcnt_next  = '0;
    case (state_reg)
      HOLD: begin
        if (lock_s2_reg) state_next = STRETCH;
      end
      STRETCH: begin
        if (!lock_s2_reg)                          state_next = HOLD;
        else if (rcnt_reg == RCNT_W'(RST_CYC - 1)) state_next = RUN;
        else                                       rcnt_next  = rcnt_reg + 1'b1;
      end
      RUN: begin
        if (!lock_s2_reg) state_next = HOLD;
      end
      default: state_next = HOLD;
    endcase
  end

  assign srst_o = (state_reg != RUN);

  logic [LED_NUM-1:0] led_reg;

  // SoC reset has priority over a simultaneous register write.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)     led_reg <= '0;
    else if (srst_o)   led_reg <= '0;
    else if (led_we_i) led_reg <= led_wdata_i;
  end

`ifdef BOARD_IO_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_reg;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) pwm_cnt_reg <= '0;
    else           pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
  end

  assign led_o = led_reg & {LED_NUM{pwm_cnt_reg < pwm_duty_i}};
`else
  assign led_o = led_reg;
`endif

endmodule
